// File: rtl/board_io_pkg.sv
// Shared types and helpers for the board I/O conditioner.
//   rst_state_e : SoC reset sequencer states
//   SYNC_STAGES : depth of every input synchroniser
//   cnt_width() : counter width for a terminal count, never below one bit
// Optional feature macro: BOARD_IO_LONG_PRESS_EN (long-press pulses).
package board_io_pkg;

   typedef enum logic [1:0] {
      ASSERT = 2'd0,
      HOLD   = 2'd1,
      RUN    = 2'd2
   } rst_state_e;

   localparam int SYNC_STAGES = 2;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/board_io_conditioner_ch.sv
// Single-bit input conditioner: 2-flop synchroniser, debounce, edge pulses
// and (with BOARD_IO_LONG_PRESS_EN) a one-shot long-press pulse.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   raw_i     : asynchronous board level
//   mask_i    : suppresses all pulses while high (SoC held in reset)
//   level_o   : debounced level
//   rise_o    : 1-cycle pulse on accepted 0->1
//   fall_o    : 1-cycle pulse on accepted 1->0
//   long_o    : 1-cycle long-press pulse, tied 0 without the macro
module io_debounce_ch
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int LONG_PRESS_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   input  logic mask_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic long_o
);

   localparam int             DW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   stable_q, stable_d;
   logic [DW-1:0]          db_cnt_q, db_cnt_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   sync_lvl;
   logic                   accept;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
      stable_d = stable_q;
      db_cnt_d = '0;
      accept   = 1'b0;
      // Any return to the stable level clears the count, so a glitch
      // shorter than the debounce window never gets accepted.
      if (sync_lvl != stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            accept   = 1'b1;
            stable_d = sync_lvl;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
      rise_d = accept &  sync_lvl & ~mask_i;
      fall_d = accept & ~sync_lvl & ~mask_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         db_cnt_q <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign level_o = stable_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

`ifdef BOARD_IO_LONG_PRESS_EN
   localparam int            LW     = cnt_width(LONG_PRESS_CYCLES + 1);
   localparam logic [LW-1:0] LP_MAX = LW'(LONG_PRESS_CYCLES);

   logic [LW-1:0] lp_cnt_q, lp_cnt_d;
   logic          long_q, long_d;

   always_comb begin
      lp_cnt_d = lp_cnt_q;
      long_d   = 1'b0;
      // Either accepted edge restarts the count; saturating at LP_MAX
      // makes the pulse one-shot until the next press.
      if (accept) begin
         lp_cnt_d = '0;
      end else if (stable_q && (lp_cnt_q != LP_MAX)) begin
         lp_cnt_d = lp_cnt_q + 1'b1;
         long_d   = (lp_cnt_d == LP_MAX) & ~mask_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lp_cnt_q <= '0;
         long_q   <= 1'b0;
      end else begin
         lp_cnt_q <= lp_cnt_d;
         long_q   <= long_d;
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: rtl/board_io_conditioner.sv
// Board I/O conditioner top: N_CH debounced input channels plus the SoC
// reset sequencer driven by the board reset button.
// Optional feature macro: BOARD_IO_LONG_PRESS_EN (long-press pulses).
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   ext_rst_ni  : board reset button, asynchronous, active-low
//   raw_i       : raw asynchronous button/switch levels
//   level_o     : debounced levels
//   rise_o/fall_o/long_o : 1-cycle event pulses, masked during SoC reset
//   sys_rst_o   : active-high SoC reset, sys_rst_no its inverse
//   ready_o     : high while the sequencer is in RUN
//
// state  | meaning
// ASSERT | SoC reset held, hold counter cleared, waiting for button release
// HOLD   | button released, counting RST_HOLD_CYCLES before release
// RUN    | SoC reset released, pulses enabled
module board_io_conditioner
   import board_io_pkg::*;
#(
   parameter int N_CH              = 8,
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int RST_HOLD_CYCLES   = 64,
   parameter int LONG_PRESS_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ext_rst_ni,
   input  logic [N_CH-1:0] raw_i,
   output logic [N_CH-1:0] level_o,
   output logic [N_CH-1:0] rise_o,
   output logic [N_CH-1:0] fall_o,
   output logic [N_CH-1:0] long_o,
   output logic            sys_rst_o,
   output logic            sys_rst_no,
   output logic            ready_o
);

   localparam int            HW        = cnt_width(RST_HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      io_debounce_ch #(
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .raw_i   (raw_i[i]),
         .mask_i  (sys_rst_o),
         .level_o (level_o[i]),
         .rise_o  (rise_o[i]),
         .fall_o  (fall_o[i]),
         .long_o  (long_o[i])
      );
   end

   rst_state_e             state_q, state_d;
   logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
   logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
   logic                   sys_rst_q, sys_rst_d;
   logic                   ready_q, ready_d;
   logic                   ext_released;

   // Synchroniser resets to 0 so the button reads as pressed out of reset.
   assign ext_released = ext_sync_q[SYNC_STAGES-1];

   always_comb begin
      ext_sync_d = {ext_sync_q[SYNC_STAGES-2:0], ext_rst_ni};
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ASSERT: begin
            hold_cnt_d = '0;
            if (ext_released) state_d = HOLD;
         end
         HOLD: begin
            if (!ext_released) begin
               state_d    = ASSERT;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!ext_released) state_d = ASSERT;
         end
         default: begin
            state_d    = ASSERT;
            hold_cnt_d = '0;
         end
      endcase
      sys_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ASSERT;
         hold_cnt_q <= '0;
         ext_sync_q <= '0;
         sys_rst_q  <= 1'b1;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         ext_sync_q <= ext_sync_d;
         sys_rst_q  <= sys_rst_d;
         ready_q    <= ready_d;
      end
   end

   assign sys_rst_o  = sys_rst_q;
   assign sys_rst_no = ~sys_rst_q;
   assign ready_o    = ready_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
module tb_board_io_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_rst_ni;
   logic [3:0] raw_i;
   logic [3:0] level_o, rise_o, fall_o, long_o;
   logic       sys_rst_o, sys_rst_no, ready_o;

   int checks = 0;
   int errors = 0;
   int rise_cnt [4] = '{default: 0};
   int fall_cnt [4] = '{default: 0};
   int long_cnt [4] = '{default: 0};
   int snap_r [4];
   int snap_f [4];
   int snap_l [4];
   logic [3:0] exp_long;

   board_io_conditioner #(
      .N_CH              (4),
      .DEBOUNCE_CYCLES   (4),
      .RST_HOLD_CYCLES   (8),
      .LONG_PRESS_CYCLES (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ext_rst_ni (ext_rst_ni),
      .raw_i      (raw_i),
      .level_o    (level_o),
      .rise_o     (rise_o),
      .fall_o     (fall_o),
      .long_o     (long_o),
      .sys_rst_o  (sys_rst_o),
      .sys_rst_no (sys_rst_no),
      .ready_o    (ready_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         rise_cnt[i] += int'(rise_o[i]);
         fall_cnt[i] += int'(fall_o[i]);
         long_cnt[i] += int'(long_o[i]);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      for (int i = 0; i < 4; i++) begin
         snap_r[i] = rise_cnt[i];
         snap_f[i] = fall_cnt[i];
         snap_l[i] = long_cnt[i];
      end
   endtask

   initial begin
`ifdef BOARD_IO_LONG_PRESS_EN
      exp_long = 4'b1100;
`else
      exp_long = 4'b0000;
`endif
      // reset values
      rst = 1'b1; ext_rst_ni = 1'b1; raw_i = 4'b0000;
      step(5);
      chk("rst_level", level_o, 0);
      chk("rst_rise", rise_o, 0);
      chk("rst_fall", fall_o, 0);
      chk("rst_long", long_o, 0);
      chk("rst_sys_rst", sys_rst_o, 1);
      chk("rst_sys_rst_n", sys_rst_no, 0);
      chk("rst_ready", ready_o, 0);

      // reset release: sys_rst stays high for 2 + 8 edges
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("release_hold", sys_rst_o, 1);
      end
      step(1);
      chk("release_sys_rst", sys_rst_o, 0);
      chk("release_sys_rst_n", sys_rst_no, 1);
      chk("release_ready", ready_o, 1);

      // clean press on channel 0
      snap();
      raw_i[0] = 1'b1;
      step(5);
      chk("press_level_early", level_o, 0);
      step(1);
      chk("press_level", level_o, 4'b0001);
      chk("press_rise", rise_o, 4'b0001);
      step(1);
      chk("press_rise_end", rise_o, 0);
      step(5);
      raw_i[0] = 1'b0;
      step(5);
      chk("release_level_early", level_o, 4'b0001);
      step(1);
      chk("release_level", level_o, 0);
      chk("release_fall", fall_o, 4'b0001);
      step(1);
      chk("press_rise_count", rise_cnt[0] - snap_r[0], 1);
      chk("press_fall_count", fall_cnt[0] - snap_f[0], 1);

      // glitch on channel 1: three cycles high is rejected
      snap();
      raw_i[1] = 1'b1;
      step(3);
      raw_i[1] = 1'b0;
      step(10);
      chk("glitch_level", level_o, 0);
      chk("glitch_rise_count", rise_cnt[1] - snap_r[1], 0);
      chk("glitch_fall_count", fall_cnt[1] - snap_f[1], 0);

      // two channels pressed together, held 40 cycles (long press)
      snap();
      raw_i = 4'b1100;
      step(6);
      chk("dual_rise", rise_o, 4'b1100);
      chk("dual_level", level_o, 4'b1100);
      for (int i = 0; i < 19; i++) begin
         step(1);
         chk("long_quiet", long_o, 0);
      end
      step(1);
      chk("long_pulse", long_o, exp_long);
      step(1);
      chk("long_pulse_end", long_o, 0);
      step(13);
      raw_i = 4'b0000;
      step(6);
      chk("dual_fall", fall_o, 4'b1100);
      step(1);
      chk("long_count2", long_cnt[2] - snap_l[2], (exp_long[2]) ? 1 : 0);
      chk("long_count3", long_cnt[3] - snap_l[3], (exp_long[3]) ? 1 : 0);
      chk("dual_rise_count", rise_cnt[2] - snap_r[2], 1);

      // ext reset pulse in RUN, with a press inside the reset window
      snap();
      ext_rst_ni = 1'b0;
      step(1);
      ext_rst_ni = 1'b1;
      raw_i[0]   = 1'b1;
      chk("ext_e0", sys_rst_o, 0);
      step(1);
      chk("ext_e1", sys_rst_o, 0);
      step(1);
      chk("ext_asserted", sys_rst_o, 1);
      chk("ext_ready_low", ready_o, 0);
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("ext_hold", sys_rst_o, 1);
      end
      step(1);
      chk("ext_rerun", sys_rst_o, 0);
      chk("ext_ready", ready_o, 1);
      chk("ext_press_level", level_o, 4'b0001);
      chk("ext_press_masked", rise_cnt[0] - snap_r[0], 0);

      // switches held through reset
      snap();
      rst   = 1'b1;
      raw_i = 4'b1010;
      step(3);
      chk("held_rst_level", level_o, 0);
      rst = 1'b0;
      step(9);
      chk("held_level", level_o, 4'b1010);
      chk("held_not_ready", ready_o, 0);
      step(2);
      chk("held_ready", ready_o, 1);
      chk("held_rise_count", rise_cnt[1] + rise_cnt[3] - snap_r[1] - snap_r[3], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
